// File: rtl/wiener_pkg.sv
// wiener_pkg: shared state encoding, default sizing and width helpers for
// the Wiener decoder feeder.
package wiener_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    FIRE = 3'd2,
    BUSY = 3'd3,
    COEF = 3'd4
  } state_t;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_COL_NUM = 128;
  localparam int DEF_ROW_NUM = 2;
  localparam int DEF_TIMEOUT = 8192;

  // Feature RAM address width: one spare bit above the channel index.
  function automatic int serial_col(input int col);
    return $clog2(col) + 1;
  endfunction

  // Coefficient RAM address width for a ROW x COL matrix.
  function automatic int addr_wid(input int col, input int row);
    return $clog2(col * row) + 1;
  endfunction

endpackage

// File: rtl/wiener_wdt.sv
// wiener_wdt: BUSY watchdog. Counts enabled cycles since the last clear and
// flags the cycle in which the count sits at TIMEOUT-1.
module wiener_wdt
  import wiener_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] r_cnt;

  // Cycle counter; clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_expire = i_en && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wiener_feeder.sv
// wiener_feeder: writer-side front end for the Wiener decoder core.
// Streams one frame of COL_NUM feature samples into the core's feature RAM,
// pulses start, then blocks input until finish_cal or a watchdog timeout.
// Build option WIENER_COEF_LOAD_EN adds a coefficient stream that loads the
// ROW_NUM x COL_NUM weight matrix into the coefficient RAM from IDLE.
module wiener_feeder
  import wiener_pkg::*;
#(
  parameter  int WIDTH      = DEF_WIDTH,
  parameter  int COL_NUM    = DEF_COL_NUM,
  parameter  int ROW_NUM    = DEF_ROW_NUM,
  parameter  int TIMEOUT    = DEF_TIMEOUT,
  localparam int Serial_COL = serial_col(COL_NUM),
  localparam int ADDR_WID   = addr_wid(COL_NUM, ROW_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      s_data,
  input  logic                  s_last,
  output logic [Serial_COL-1:0] wr_data_addr,
  output logic                  ram_wr_data_en,
  output logic [WIDTH-1:0]      ram_data_wr_in,
  output logic                  start,
  input  logic                  finish_cal,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt,
  output logic                  len_err,
  output logic                  tmo_err,
`ifdef WIENER_COEF_LOAD_EN
  input  logic                  c_valid,
  output logic                  c_ready,
  input  logic [WIDTH/2-1:0]    c_data,
  output logic                  coef_done,
`endif
  output logic [ADDR_WID-1:0]   wr_addr,
  output logic                  ram_wr_en,
  output logic [WIDTH/2-1:0]    ram_data_in
);

  state_t                r_state;
  logic [Serial_COL-1:0] r_col_cnt;
  logic                  r_s_ready;
  logic                  r_start;
  logic                  r_frame_done;
  logic [15:0]           r_frame_cnt;
  logic                  r_len_err;
  logic                  r_tmo_err;
  logic [Serial_COL-1:0] r_wr_data_addr;
  logic                  r_ram_wr_data_en;
  logic [WIDTH-1:0]      r_ram_data_wr_in;
  logic                  w_s_hs;
  logic                  w_expire;

`ifdef WIENER_COEF_LOAD_EN
  logic                  r_c_ready;
  logic                  r_coef_done;
  logic [ADDR_WID-1:0]   r_coef_cnt;
  logic [ADDR_WID-1:0]   r_wr_addr;
  logic                  r_ram_wr_en;
  logic [WIDTH/2-1:0]    r_ram_data_in;
  logic                  w_c_hs;

  // A pending coefficient word in IDLE takes the cycle away from features.
  assign s_ready = r_s_ready & ~((r_state == IDLE) & c_valid);
  assign w_c_hs  = c_valid & r_c_ready;
`else
  assign s_ready = r_s_ready;
`endif

  assign w_s_hs = s_valid & s_ready;

  // Watchdog is zeroed while firing and runs only while the core computes.
  wiener_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (r_state == FIRE),
    .i_en     (r_state == BUSY),
    .o_expire (w_expire)
  );

  // Feature RAM write port: one registered strobe per accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_wr_data_en <= 1'b0;
      r_wr_data_addr   <= '0;
      r_ram_data_wr_in <= '0;
    end else begin
      r_ram_wr_data_en <= w_s_hs;
      if (w_s_hs) begin
        r_wr_data_addr   <= r_col_cnt;
        r_ram_data_wr_in <= s_data;
      end
    end
  end

  // Frame sequencing FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_col_cnt    <= '0;
      r_s_ready    <= 1'b0;
      r_start      <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
      r_len_err    <= 1'b0;
      r_tmo_err    <= 1'b0;
`ifdef WIENER_COEF_LOAD_EN
      r_c_ready    <= 1'b0;
      r_coef_done  <= 1'b0;
      r_coef_cnt   <= '0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      r_len_err    <= 1'b0;
      r_tmo_err    <= 1'b0;
`ifdef WIENER_COEF_LOAD_EN
      r_coef_done  <= 1'b0;
`endif
      case (r_state)
        IDLE, LOAD: begin
          r_s_ready <= 1'b1;
`ifdef WIENER_COEF_LOAD_EN
          if (r_state == IDLE && c_valid) begin
            r_state   <= COEF;
            r_s_ready <= 1'b0;
            r_c_ready <= 1'b1;
          end else
`endif
          if (w_s_hs) begin
            if (r_col_cnt == Serial_COL'(COL_NUM - 1)) begin
              // Full frame: fire even when s_last is missing, but flag it.
              r_state   <= FIRE;
              r_col_cnt <= '0;
              r_s_ready <= 1'b0;
              r_len_err <= ~s_last;
            end else if (s_last) begin
              // Short frame: drop it; the stale RAM is never computed.
              r_state   <= IDLE;
              r_col_cnt <= '0;
              r_len_err <= 1'b1;
            end else begin
              r_state   <= LOAD;
              r_col_cnt <= r_col_cnt + 1'b1;
            end
          end
        end
        FIRE: begin
          // Two cycles: the first raises start, the second drops it.
          if (!r_start) begin
            r_start <= 1'b1;
          end else begin
            r_start <= 1'b0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (finish_cal) begin
            r_frame_done <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + 1'b1;
            r_state      <= IDLE;
            r_s_ready    <= 1'b1;
          end else if (w_expire) begin
            r_tmo_err <= 1'b1;
            r_state   <= IDLE;
            r_s_ready <= 1'b1;
          end
        end
`ifdef WIENER_COEF_LOAD_EN
        COEF: begin
          if (w_c_hs) begin
            if (r_coef_cnt == ADDR_WID'(COL_NUM * ROW_NUM - 1)) begin
              r_coef_done <= 1'b1;
              r_coef_cnt  <= '0;
              r_c_ready   <= 1'b0;
              r_state     <= IDLE;
              r_s_ready   <= 1'b1;
            end else begin
              r_coef_cnt <= r_coef_cnt + 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state   <= IDLE;
          r_s_ready <= 1'b0;
          r_start   <= 1'b0;
        end
      endcase
    end
  end

`ifdef WIENER_COEF_LOAD_EN
  // Coefficient RAM write port: row r lands at r*COL_NUM onward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_wr_en   <= 1'b0;
      r_wr_addr     <= '0;
      r_ram_data_in <= '0;
    end else begin
      r_ram_wr_en <= w_c_hs;
      if (w_c_hs) begin
        r_wr_addr     <= r_coef_cnt;
        r_ram_data_in <= c_data;
      end
    end
  end

  assign c_ready     = r_c_ready;
  assign coef_done   = r_coef_done;
  assign wr_addr     = r_wr_addr;
  assign ram_wr_en   = r_ram_wr_en;
  assign ram_data_in = r_ram_data_in;
`else
  assign wr_addr     = '0;
  assign ram_wr_en   = 1'b0;
  assign ram_data_in = '0;
`endif

  assign wr_data_addr   = r_wr_data_addr;
  assign ram_wr_data_en = r_ram_wr_data_en;
  assign ram_data_wr_in = r_ram_data_wr_in;
  assign start          = r_start;
  assign frame_done     = r_frame_done;
  assign frame_cnt      = r_frame_cnt;
  assign len_err        = r_len_err;
  assign tmo_err        = r_tmo_err;

endmodule

// File: doc/wiener_feeder.md
# wiener_feeder

- Writer-side front end for the Wiener decoder core.
- Accepts a stream of per-channel neural features, one frame of COL_NUM samples, and writes it into the core's feature RAM port.
- Pulses the core's start after the last write commits, then holds off new input until the core reports finish.
- Optionally streams the ROW_NUM×COL_NUM signed 8-bit weight matrix into the core's coefficient RAM port.

## Interface
Parameters:
- WIDTH, 16, feature sample width (signed)
- COL_NUM, 128, samples per frame (channels)
- ROW_NUM, 2, decoder output rows; sets coefficient count
- TIMEOUT, 8192, max cycles in BUSY before abort
- localparam Serial_COL = $clog2(COL_NUM)+1; ADDR_WID = $clog2(COL_NUM*ROW_NUM)+1

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  feature sample valid
- s_ready  out  1  feature sample accepted when s_valid&s_ready
- s_data  in  WIDTH  feature sample
- s_last  in  1  marks final sample of a frame
- wr_data_addr  out  Serial_COL  feature RAM write address
- ram_wr_data_en  out  1  feature RAM write enable
- ram_data_wr_in  out  WIDTH  feature RAM write data
- start  out  1  one-cycle compute request to core
- finish_cal  in  1  core completion pulse
- frame_done  out  1  one-cycle pulse, frame computed
- frame_cnt  out  16  completed frames, wraps at 65535→0
- len_err  out  1  one-cycle pulse, frame length violation
- tmo_err  out  1  one-cycle pulse, BUSY timeout
- c_valid / c_ready / c_data  in / out / in  1 / 1 / WIDTH/2  coefficient stream (macro only)
- wr_addr  out  ADDR_WID  coefficient RAM write address
- ram_wr_en  out  1  coefficient RAM write enable
- ram_data_in  out  WIDTH/2  coefficient RAM write data
- coef_done  out  1  one-cycle pulse, full matrix written (macro only)

## Operation
- States: IDLE (col_cnt=0), LOAD (partial frame), FIRE, BUSY, COEF.
- s_ready = 1 in IDLE and LOAD only; decoded from state.
- Each accepted sample registers wr_data_addr=col_cnt, ram_data_wr_in=s_data, ram_wr_data_en=1; col_cnt increments.
- IDLE → LOAD on first accepted sample.
- Early s_last (col_cnt<COL_NUM-1):
  - len_err pulse.
  - Frame discarded, col_cnt←0, → IDLE.
  - No start.
  - RAM contents stale but never computed.
- Sample col_cnt=COL_NUM-1 accepted → FIRE, col_cnt←0.
  - If s_last=0 on it: len_err pulse, frame still fired.
- FIRE: start=1 for exactly one cycle, → BUSY, watchdog cleared.
- BUSY:
  - finish_cal=1 → frame_done pulse, frame_cnt+1, → IDLE.
  - Watchdog reaches TIMEOUT-1 → tmo_err pulse, → IDLE; frame_cnt unchanged.
- finish_cal outside BUSY is ignored.
- Feature data passes unmodified; no arithmetic on samples.
- frame_cnt is modulo 2^16.
- Reset mid-frame or mid-BUSY: all state cleared. The core must be reset together with this block.
- Reset values: every output 0, including s_ready, c_ready, frame_cnt, wr_addr, wr_data_addr. State=IDLE.

## Timing
- Handshake at cycle t → write strobe visible in t+1. RAM captures at the end of t+1.
- Last sample accepted at t → FIRE at t+1 → start high during t+2 only → BUSY from t+3.
- finish_cal at cycle u (in BUSY) → frame_done and frame_cnt update visible at u+1. s_ready=1 at u+1.
- Back-to-back frames: new samples accepted from u+1. Never during FIRE or BUSY, so the core never reads a RAM being overwritten.
- Throughput: one sample per cycle while s_ready=1.

## Configuration
- Macro WIENER_COEF_LOAD_EN.
- Defined:
  - c_* ports and coef_done exist.
  - IDLE with c_valid=1 → COEF; c_valid has priority over s_valid in IDLE. In LOAD, c_valid is ignored.
  - COEF: c_ready=1, s_ready=0. Each handshake registers wr_addr=coef_cnt, ram_data_in=c_data, ram_wr_en=1.
  - After COL_NUM*ROW_NUM words: coef_done pulse, coef_cnt←0, → IDLE.
  - Row r of the matrix occupies addresses r*COL_NUM…r*COL_NUM+COL_NUM-1.
- Undefined:
  - c_* ports and coef_done are absent; COEF state is not built.
  - wr_addr, ram_wr_en, ram_data_in are tied to 0.
  - Coefficients come from the RAM init file.

## Structure
- Package wiener_pkg holds:
  - The state enum (IDLE/LOAD/FIRE/BUSY/COEF).
  - Default COL_NUM, ROW_NUM, WIDTH and TIMEOUT constants.
  - The Serial_COL/ADDR_WID derivation functions.
- One sub-module, wiener_wdt:
  - Clear and enable inputs, TIMEOUT parameter.
  - Outputs an expire pulse.
  - Instantiated once for BUSY supervision.

## Test plan
- Reset release, 128 samples 0x0001…0x0080, s_last on the 128th → 128 writes at addr 0…127, start one pulse 2 cycles after the last handshake, s_ready=0 until finish_cal.
- finish_cal 2000 cycles after start → frame_done pulse, frame_cnt=1. A second frame is accepted the next cycle and frame_cnt=2 after its finish.
- s_last on sample 50 → len_err pulse, no start, s_ready stays 1. The next full frame computes normally.
- No finish_cal after start → tmo_err after 8192 cycles, → IDLE, frame_cnt unchanged.
- rst_n low mid-frame at sample 70 → all outputs 0. The next frame starts writing at addr 0.
- WIENER_COEF_LOAD_EN: 256 coefficients 0x80…0x7F in IDLE with s_valid also high → coefficients win, wr_addr 0…255, coef_done once, then the feature frame proceeds.
